// File: rtl/irq_gateway_arb_pkg.sv
// Shared types and constants for the interrupt gateway arbiter:
// gateway state encoding, reserved IDs/addresses and default sizing.
package irq_gateway_arb_pkg;

  localparam int DEFAULT_NSRC   = 6;
  localparam int DEFAULT_PRIO_W = 2;

  localparam logic [2:0] ID_NONE     = 3'd0;
  localparam logic [2:0] THRESH_ADDR = 3'd7;

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: latches a level request into PENDING, holds it INFLIGHT
// from claim until the matching completion arrives.
module irq_gateway
  import irq_gateway_arb_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      src,
  input  logic      enable,
  input  logic      dis_wr,
  input  logic      claim_win,
  input  logic      cmpl_hit,
  output gw_state_e state
);

  gw_state_e state_d;
  gw_state_e state_q;

  // Next-state logic; a claim win takes precedence over a disable in the same clock
  // because the arbiter has already reported this source as claimed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GW_IDLE: begin
        if (src && enable) state_d = GW_PENDING;
        else               state_d = GW_IDLE;
      end
      GW_PENDING: begin
        if (claim_win)   state_d = GW_INFLIGHT;
        else if (dis_wr) state_d = GW_IDLE;
        else             state_d = GW_PENDING;
      end
      GW_INFLIGHT: begin
        if (cmpl_hit) state_d = GW_IDLE;
        else          state_d = GW_INFLIGHT;
      end
      default: state_d = GW_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= GW_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/irq_gateway_arb.sv
// Level-interrupt gateway bank with per-source enable/priority, a global
// threshold, combinational priority arbitration and a registered claim port.
module irq_gateway_arb
  import irq_gateway_arb_pkg::*;
#(
  parameter int NSRC   = DEFAULT_NSRC,
  parameter int PRIO_W = DEFAULT_PRIO_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NSRC-1:0]   src,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [PRIO_W:0]   cfg_wdata,
  output logic              irq,
  input  logic              claim_req,
  output logic              claim_vld,
  output logic [2:0]        claim_id,
  input  logic              cmpl_vld,
  input  logic [2:0]        cmpl_id
);

  logic [NSRC-1:0]   enable_d, enable_q;
  logic [PRIO_W-1:0] prio_d [NSRC];
  logic [PRIO_W-1:0] prio_q [NSRC];
  logic [PRIO_W-1:0] thresh_d, thresh_q;

  logic              irq_d, irq_q;
  logic              claim_vld_d, claim_vld_q;
  logic [2:0]        claim_id_d, claim_id_q;

  gw_state_e         gw_state [NSRC];
  logic [NSRC-1:0]   eligible;
  logic [NSRC-1:0]   dis_wr;
  logic [NSRC-1:0]   claim_win;
  logic [NSRC-1:0]   cmpl_hit;

  logic              win_found;
  logic [PRIO_W-1:0] win_prio;
  logic [2:0]        win_id;

  // Config decode; address 7 always means threshold, even when NSRC is 7.
  always_comb begin
    enable_d = enable_q;
    prio_d   = prio_q;
    thresh_d = thresh_q;
    dis_wr   = '0;
    if (cfg_we) begin
      if (cfg_addr == THRESH_ADDR) begin
        thresh_d = cfg_wdata[PRIO_W-1:0];
      end else begin
        for (int i = 0; i < NSRC; i++) begin
          if (cfg_addr == 3'(i + 1)) begin
            enable_d[i] = cfg_wdata[PRIO_W];
            prio_d[i]   = cfg_wdata[PRIO_W-1:0];
            dis_wr[i]   = ~cfg_wdata[PRIO_W];
          end else begin
            dis_wr[i]   = 1'b0;
          end
        end
      end
    end else begin
      thresh_d = thresh_q;
    end
  end

  // Eligibility and winner search; strict '>' keeps the lowest ID on ties.
  always_comb begin
    win_found = 1'b0;
    win_prio  = '0;
    win_id    = ID_NONE;
    for (int i = 0; i < NSRC; i++) begin
      eligible[i] = (gw_state[i] == GW_PENDING) && enable_q[i] && (prio_q[i] > thresh_q);
      if (eligible[i] && (!win_found || (prio_q[i] > win_prio))) begin
        win_found = 1'b1;
        win_prio  = prio_q[i];
        win_id    = 3'(i + 1);
      end else begin
        win_found = win_found;
      end
    end
  end

  // Claim/completion steering and registered response next-state.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      claim_win[i] = claim_req && win_found && (win_id == 3'(i + 1));
      cmpl_hit[i]  = cmpl_vld && (cmpl_id == 3'(i + 1));
    end
    irq_d       = win_found;
    claim_vld_d = claim_req;
    if (claim_req) claim_id_d = win_id;
    else           claim_id_d = claim_id_q;
  end

  // Config and response registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      enable_q    <= '0;
      for (int i = 0; i < NSRC; i++) prio_q[i] <= '0;
      thresh_q    <= '0;
      irq_q       <= 1'b0;
      claim_vld_q <= 1'b0;
      claim_id_q  <= ID_NONE;
    end else begin
      enable_q    <= enable_d;
      prio_q      <= prio_d;
      thresh_q    <= thresh_d;
      irq_q       <= irq_d;
      claim_vld_q <= claim_vld_d;
      claim_id_q  <= claim_id_d;
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clock     (clock),
      .reset     (reset),
      .src       (src[g]),
      .enable    (enable_q[g]),
      .dis_wr    (dis_wr[g]),
      .claim_win (claim_win[g]),
      .cmpl_hit  (cmpl_hit[g]),
      .state     (gw_state[g])
    );
  end

  assign irq       = irq_q;
  assign claim_vld = claim_vld_q;
  assign claim_id  = claim_id_q;

endmodule

// File: tb/tb_irq_gateway_arb.sv
// Directed bench for irq_gateway_arb: claim responses are checked against a
// queue of expected IDs; irq and held claim_id are checked at directed points.
module tb_irq_gateway_arb;
  import irq_gateway_arb_pkg::*;

  localparam int NSRC   = 6;
  localparam int PRIO_W = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NSRC-1:0]   src;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [PRIO_W:0]   cfg_wdata;
  logic              irq;
  logic              claim_req;
  logic              claim_vld;
  logic [2:0]        claim_id;
  logic              cmpl_vld;
  logic [2:0]        cmpl_id;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q [$];

  irq_gateway_arb #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .src       (src),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .irq       (irq),
    .claim_req (claim_req),
    .claim_vld (claim_vld),
    .claim_id  (claim_id),
    .cmpl_vld  (cmpl_vld),
    .cmpl_id   (cmpl_id)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every claim_vld pulse consumes one expected ID.
  always @(negedge clock) begin
    if (claim_vld === 1'b1) begin
      chk("claim_unexpected", 8'(exp_q.size() == 0), 8'd0);
      if (exp_q.size() != 0) chk("claim_id", 8'(claim_id), 8'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input logic [2:0] addr, input logic [PRIO_W:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = '0;
  endtask

  task automatic claim(input logic [2:0] exp_id);
    exp_q.push_back(exp_id);
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
  endtask

  task automatic complete(input logic [2:0] id);
    cmpl_vld = 1'b1; cmpl_id = id;
    tick();
    cmpl_vld = 1'b0; cmpl_id = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0; src = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; src = '0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = '0;
    claim_req = 1'b0; cmpl_vld = 1'b0; cmpl_id = 3'd0;
    tick(); tick();
    chk("rst_irq", 8'(irq), 8'd0);
    chk("rst_claim_vld", 8'(claim_vld), 8'd0);
    chk("rst_claim_id", 8'(claim_id), 8'd0);
    reset = 1'b1;

    // Basic claim/complete on ID 3, priority 2.
    cfg(3'd3, 3'b110);
    src = 6'b000100;
    tick();
    chk("basic_irq_lat1", 8'(irq), 8'd0);
    tick();
    chk("basic_irq_rise", 8'(irq), 8'd1);
    claim(3'd3);
    tick();
    chk("basic_irq_fall", 8'(irq), 8'd0);
    chk("basic_id_hold", 8'(claim_id), 8'd3);
    src = '0;
    complete(3'd3);
    tick();
    chk("basic_idle_irq", 8'(irq), 8'd0);
    claim(3'd0);

    // Priority and tie-break.
    do_reset();
    cfg(3'd2, 3'b111);
    cfg(3'd5, 3'b111);
    cfg(3'd1, 3'b101);
    src = 6'b010011;
    tick(); tick();
    chk("prio_irq", 8'(irq), 8'd1);
    claim(3'd2);
    claim(3'd5);
    claim(3'd1);
    claim(3'd0);
    chk("prio_irq_drained", 8'(irq), 8'd0);
    complete(3'd2);
    tick();
    claim(3'd2);

    // Threshold and priority 0.
    do_reset();
    cfg(3'd4, 3'b101);
    cfg(3'd7, 3'b001);
    src = 6'b001000;
    tick(); tick(); tick();
    chk("thresh_block", 8'(irq), 8'd0);
    cfg(3'd7, 3'b000);
    chk("thresh_lat", 8'(irq), 8'd0);
    tick();
    chk("thresh_open", 8'(irq), 8'd1);
    cfg(3'd4, 3'b100);
    tick(); tick();
    chk("prio0_irq", 8'(irq), 8'd0);

    // Disable and completion filtering on ID 1.
    do_reset();
    cfg(3'd1, 3'b101);
    src = 6'b000001;
    tick(); tick();
    chk("dis_irq_before", 8'(irq), 8'd1);
    cfg(3'd1, 3'b001);
    tick();
    chk("dis_irq_after", 8'(irq), 8'd0);
    claim(3'd0);
    cfg(3'd1, 3'b101);
    tick(); tick();
    chk("reen_irq", 8'(irq), 8'd1);
    claim(3'd1);
    cfg(3'd1, 3'b001);
    cfg(3'd1, 3'b101);
    tick(); tick();
    chk("inflight_irq", 8'(irq), 8'd0);
    claim(3'd0);
    complete(3'd7);
    complete(3'd0);
    tick();
    claim(3'd0);
    complete(3'd1);
    tick();
    claim(3'd1);

    // Simultaneous claim+complete, then reset mid-INFLIGHT.
    do_reset();
    cfg(3'd6, 3'b111);
    cfg(3'd3, 3'b110);
    src = 6'b100100;
    tick(); tick();
    claim(3'd6);
    exp_q.push_back(3'd3);
    claim_req = 1'b1; cmpl_vld = 1'b1; cmpl_id = 3'd6;
    tick();
    claim_req = 1'b0; cmpl_vld = 1'b0; cmpl_id = 3'd0;
    chk("sim_irq_s", 8'(irq), 8'd1);
    tick();
    chk("sim_irq_gap", 8'(irq), 8'd0);
    tick();
    chk("sim_repend_irq", 8'(irq), 8'd1);
    claim(3'd6);
    reset = 1'b0;
    claim_req = 1'b1; cmpl_vld = 1'b1; cmpl_id = 3'd6;
    cfg_we = 1'b1; cfg_addr = 3'd7; cfg_wdata = 3'b011;
    tick(); tick();
    chk("midrst_irq", 8'(irq), 8'd0);
    chk("midrst_claim_id", 8'(claim_id), 8'd0);
    chk("midrst_claim_vld", 8'(claim_vld), 8'd0);
    claim_req = 1'b0; cmpl_vld = 1'b0; cmpl_id = 3'd0;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = '0;
    reset = 1'b1;
    tick();
    chk("post_rst_vld", 8'(claim_vld), 8'd0);
    claim(3'd0);
    claim(3'd0);
    cfg(3'd6, 3'b111);
    tick(); tick();
    chk("post_rst_irq", 8'(irq), 8'd1);
    claim(3'd6);
    tick(); tick();
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_gateway_arb.md
IRQ_GATEWAY_ARB -- requirements
Module: irq_gateway_arb

Interface
REQ-001 Parameter: NSRC, default 6, number of level-sensitive interrupt sources (1..7).
REQ-002 Parameter: PRIO_W, default 2, priority field width.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clock.
REQ-005 src  input  NSRC  level interrupt lines; bit i is source ID i+1.
REQ-006 cfg_we  input  1  configuration write strobe.
REQ-007 cfg_addr  input  3  1..NSRC selects a source config; 7 selects the threshold; 0 is ignored.
REQ-008 cfg_wdata  input  PRIO_W+1  source: {enable, priority}; threshold: low PRIO_W bits.
REQ-009 irq  output  1  interrupt request to the core.
REQ-010 claim_req  input  1  single-cycle claim request.
REQ-011 claim_vld  output  1  claim response strobe.
REQ-012 claim_id  output  3  claimed source ID; 0 means none.
REQ-013 cmpl_vld  input  1  completion strobe.
REQ-014 cmpl_id  input  3  completed source ID.

Function
REQ-015 Each source SHALL run a gateway FSM with states IDLE, PENDING and INFLIGHT.
REQ-016 IDLE->PENDING on the clock where src[i]=1 and enable[i]=1.
REQ-017 PENDING->IDLE on a clock where enable[i] is written 0.
REQ-018 PENDING->INFLIGHT when that source is the winner on a claim_req clock.
REQ-019 INFLIGHT->IDLE only on cmpl_vld with cmpl_id=i+1; a disable write SHALL NOT leave INFLIGHT.
REQ-020 A source is eligible when it is PENDING, enabled and its priority is strictly greater than the threshold.
REQ-021 Winner: the eligible source with the highest priority; ties go to the lowest ID.
REQ-022 irq SHALL be registered: high exactly one clock after any source is eligible, low one clock after none is.
REQ-023 Claim: claim_vld SHALL pulse one clock after claim_req, with claim_id = the winner at the claim_req clock, or 0 if there is none.
REQ-024 A claim with no winner SHALL change no state.
REQ-025 claim_id SHALL hold its value between claim_vld pulses.
REQ-026 cmpl_vld with ID 0, an out-of-range ID, or a source not INFLIGHT SHALL be ignored.
REQ-027 With claim_req and cmpl_vld in the same clock, both SHALL take effect.
REQ-028 A source completed in a given clock SHALL NOT be claimable in that same clock.
REQ-029 A completed source whose src is still high SHALL re-enter PENDING on the next clock.
REQ-030 Config writes SHALL take effect for arbitration from the next clock.
REQ-031 Priority 0 SHALL never raise irq at any threshold.

Reset
REQ-032 While reset=0 at a clock edge, the following SHALL be forced:
- all gateways to IDLE;
- all enables to 0, priorities to 0, threshold to 0;
- irq=0, claim_vld=0, claim_id=0.
REQ-033 claim_req, cmpl_vld and cfg_we asserted during reset SHALL be discarded, with no residual effect after release.
REQ-034 Reset asserted while a source is INFLIGHT SHALL return that source to IDLE with no completion required.

Structure
REQ-035 A shared package SHALL hold:
- the gateway-state enumeration;
- ID_NONE=0 and THRESH_ADDR=7;
- the default NSRC and PRIO_W values.
REQ-036 The per-source FSM SHALL be the sub-module irq_gateway, instantiated NSRC times.
REQ-037 The arbitration tree SHALL be combinational; only the FSMs, config registers, irq and the claim response registers hold state.

Verification
REQ-038 Basic claim/complete: src[2]=1 enables ID 3 at priority 2, threshold 0; then claim_req.
- irq rises 2 clocks after src rises.
- claim_id=3 with claim_vld, and irq falls.
- cmpl_id=3 with src low leaves the source IDLE.
REQ-039 Priority and tie-break: IDs 2 and 5 at priority 3, ID 1 at priority 1, all asserted.
- Claims return 2, then 5, then 1.
- A fourth claim returns 0.
REQ-040 Threshold: ID 4 at priority 1 with threshold 1 gives irq=0; writing threshold 0 gives irq=1 two clocks later.
REQ-041 Disable and complete: ID 1 PENDING is disabled, then irq falls and a claim returns 0.
- With ID 1 INFLIGHT, a disable write keeps it INFLIGHT.
- Completion is accepted; a bogus cmpl_id=7 is ignored.
REQ-042 Simultaneous events and reset:
- claim_req with cmpl_vld for INFLIGHT ID 6 (src still high) returns another winner, and ID 6 re-pends one clock later.
- reset=0 mid-INFLIGHT clears irq and claim_id, and all IDs return 0.
